// File: rtl/audio_sample_channel.sv
// Single-voice PCM player feeding the sigma-delta DAC; fetches packed signed 8-bit samples
// over req/ack, paces them with a period counter, and applies volume when AUDIO_VOLUME_EN is defined.
module audio_sample_channel #(
  parameter int ADDR_W   = 16,
  parameter int LEN_W    = 15,
  parameter int PERIOD_W = 15
) (
  input  logic                clk,
  input  logic                reset_ni,
  input  logic                enable_i,
  input  logic [ADDR_W-1:0]   start_addr_i,
  input  logic [LEN_W-1:0]    length_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [6:0]          volume_i,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [15:0]         mem_data_i,
  output logic [7:0]          value_o,
  output logic                restart_o,
  output logic                underrun_o
);

  typedef enum logic [1:0] {IDLE, RUN, STOP_WAIT} state_t;

  state_t              state;
  logic [LEN_W-1:0]    words_left;
  logic [PERIOD_W-1:0] period_cnt;
  logic [15:0]         cur_word;
  logic [15:0]         next_word;
  logic                byte_sel;
  logic                next_valid;

  logic       tick;
  logic [7:0] sample;
  logic [7:0] shaped;

  assign tick   = (period_cnt == '0);
  assign sample = byte_sel ? cur_word[7:0] : cur_word[15:8];

`ifdef AUDIO_VOLUME_EN
  logic signed [15:0] s_ext;
  logic signed [15:0] v_ext;
  logic signed [15:0] product;
  logic signed [9:0]  scaled;
  logic [7:0]         clipped;

  always_comb begin
    s_ext   = 16'($signed(sample));
    v_ext   = $signed({9'd0, volume_i});
    product = s_ext * v_ext;
    scaled  = 10'(product >>> 6);
    if (scaled > 10'sd127)
      clipped = 8'h7f;
    else if (scaled < -10'sd128)
      clipped = 8'h80;
    else
      clipped = scaled[7:0];
  end
  assign shaped = clipped ^ 8'h80;
`else
  logic unused_volume;
  assign unused_volume = ^volume_i;
  assign shaped        = sample ^ 8'h80;
`endif

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      words_left <= '0;
      period_cnt <= '0;
      cur_word   <= '0;
      next_word  <= '0;
      byte_sel   <= 1'b1;
      next_valid <= 1'b0;
      value_o    <= 8'h80;
      restart_o  <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      restart_o  <= 1'b0;
      underrun_o <= 1'b0;
      case (state)
        IDLE: begin
          value_o <= 8'h80;
          if (enable_i) begin
            state      <= RUN;
            mem_addr_o <= start_addr_i;
            words_left <= length_i;
            period_cnt <= period_i;
            cur_word   <= '0;
            byte_sel   <= 1'b1;
            next_valid <= 1'b0;
            mem_req_o  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable_i) begin
            value_o <= 8'h80;
            // An ack landing on the same edge closes the request, so no need to wait.
            if (mem_req_o && !mem_ack_i) begin
              state <= STOP_WAIT;
            end else begin
              state     <= IDLE;
              mem_req_o <= 1'b0;
            end
          end else begin
            value_o    <= shaped;
            period_cnt <= tick ? period_i : period_cnt - PERIOD_W'(1);
            if (mem_req_o && mem_ack_i) begin
              next_word  <= mem_data_i;
              next_valid <= 1'b1;
              mem_req_o  <= 1'b0;
              if (words_left != '0) begin
                mem_addr_o <= mem_addr_o + ADDR_W'(1);
                words_left <= words_left - LEN_W'(1);
              end else begin
                mem_addr_o <= start_addr_i;
                words_left <= length_i;
                restart_o  <= 1'b1;
              end
            end
            // A request is never outstanding while next_valid is set, so the swap
            // below cannot collide with the ack update above.
            if (tick) begin
              if (!byte_sel) begin
                byte_sel <= 1'b1;
              end else if (next_valid) begin
                cur_word   <= next_word;
                byte_sel   <= 1'b0;
                next_valid <= 1'b0;
                mem_req_o  <= 1'b1;
              end else begin
                underrun_o <= 1'b1;
              end
            end
          end
        end
        STOP_WAIT: begin
          value_o <= 8'h80;
          if (mem_ack_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
          value_o   <= 8'h80;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_channel.sv
// Bench for audio_sample_channel: a sample-queue reference model predicts every clock's outputs
// while a memory responder with programmable ack delay feeds randomized words.
module tb_audio_sample_channel;

  logic        clk;
  logic        reset_ni;
  logic        enable_i;
  logic [15:0] start_addr_i;
  logic [14:0] length_i;
  logic [14:0] period_i;
  logic [6:0]  volume_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_ack_i;
  logic [15:0] mem_data_i;
  logic [7:0]  value_o;
  logic        restart_o;
  logic        underrun_o;

  audio_sample_channel dut (
    .clk(clk), .reset_ni(reset_ni), .enable_i(enable_i),
    .start_addr_i(start_addr_i), .length_i(length_i), .period_i(period_i),
    .volume_i(volume_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .value_o(value_o),
    .restart_o(restart_o), .underrun_o(underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 playing, 2 draining a request after stop.
  int          m_mode;
  int          m_k;
  int          m_p;
  int          m_idx;
  logic [15:0] m_start;
  logic [14:0] m_len;
  logic [7:0]  m_cur;
  logic [7:0]  m_rem[$];
  logic [15:0] m_buf[$];
  bit          m_out;
  logic [7:0]  e_value;
  logic        e_restart;
  logic        e_underrun;
  logic [15:0] e_addr;

  // Memory responder controls.
  logic [15:0] data_q[$];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  bit          spurious  = 0;
  bit          force_ack = 0;

  function automatic logic [7:0] map_out(logic [7:0] s, logic [6:0] v);
    int x;
    x = int'($signed(s));
`ifdef AUDIO_VOLUME_EN
    x = x * int'(v);
    x = (x >= 0) ? x / 64 : -((-x + 63) / 64);
    if (x > 127)  x = 127;
    if (x < -128) x = -128;
`else
    if (v == 7'd0) x = x + 0;
`endif
    return 8'(x) ^ 8'h80;
  endfunction

  task automatic m_update();
    bit          out_pre;
    bit          had_buf;
    bit          tick;
    logic [15:0] w;
    out_pre    = m_out;
    had_buf    = (m_buf.size() != 0);
    e_restart  = 1'b0;
    e_underrun = 1'b0;
    if (!reset_ni) begin
      m_mode = 0; m_out = 0; m_cur = 8'h00; m_start = 16'h0; m_idx = 0;
      m_buf.delete(); m_rem.delete();
      e_value = 8'h80;
    end else begin
      case (m_mode)
        0: begin
          e_value = 8'h80;
          if (enable_i) begin
            m_mode = 1; m_k = 0; m_p = int'(period_i); m_cur = 8'h00;
            m_rem.delete(); m_buf.delete(); m_out = 1;
            m_start = start_addr_i; m_len = length_i; m_idx = 0;
          end
        end
        1: begin
          if (!enable_i) begin
            e_value = 8'h80;
            if (out_pre && !mem_ack_i) m_mode = 2;
            else begin m_mode = 0; m_out = 0; end
          end else begin
            e_value = map_out(m_cur, volume_i);
            m_k++;
            tick = ((m_k % (m_p + 1)) == 0);
            if (out_pre && mem_ack_i) begin
              m_buf.push_back(mem_data_i);
              m_out = 0;
              if (m_idx == int'(m_len)) begin
                m_idx = 0; m_start = start_addr_i; m_len = length_i; e_restart = 1'b1;
              end else m_idx++;
            end
            if (tick) begin
              if (m_rem.size() != 0) m_cur = m_rem.pop_front();
              else if (had_buf) begin
                w = m_buf.pop_front();
                m_cur = w[15:8];
                m_rem.push_back(w[7:0]);
                m_out = 1;
              end else e_underrun = 1'b1;
            end
          end
        end
        default: begin
          e_value = 8'h80;
          if (mem_ack_i) begin m_mode = 0; m_out = 0; end
        end
      endcase
    end
    e_addr = m_start + 16'(m_idx);
  endtask

  // One clock: choose the ack, advance the model, then sample just after the edge.
  task automatic cycle();
    logic a;
    a = 1'b0;
    if (force_ack) a = 1'b1;
    else if (m_out) begin
      if (wait_cnt >= ack_delay) a = 1'b1;
      else wait_cnt++;
    end else if (spurious && $urandom_range(0, 5) == 0) a = 1'b1;
    mem_ack_i = a;
    if (a && m_out && data_q.size() != 0) mem_data_i = data_q.pop_front();
    else mem_data_i = 16'($urandom);
    m_update();
    if (!m_out) wait_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0; enable_i = 1'b0; force_ack = 0; spurious = 0;
    data_q.delete();
    cycle();
    reset_ni = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    reset_ni = 1'b0; enable_i = 1'b0;
    cycle(); cycle();
    checks++; if (value_o !== 8'h80) begin errors++; $display("FAIL reset_value got %h exp 80", value_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req_o); end
    checks++; if (mem_addr_o !== 16'h0) begin errors++; $display("FAIL reset_addr got %h exp 0000", mem_addr_o); end
    checks++; if (restart_o !== 1'b0) begin errors++; $display("FAIL reset_restart got %b exp 0", restart_o); end
    checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", underrun_o); end
    reset_ni = 1'b1;
    cycle();
    checks++; if (value_o !== e_value) begin errors++; $display("FAIL idle_value got %h exp %h", value_o, e_value); end
  endtask

  task automatic test_playback();
    do_reset();
    start_addr_i = 16'h0100; length_i = 15'd1; period_i = 15'd3; volume_i = 7'd64;
    ack_delay = 0;
    data_q = '{16'h7F80, 16'h0140, 16'h7F80, 16'h0140};
    enable_i = 1'b1;
    for (int i = 0; i < 48; i++) begin
      cycle();
      checks++; if (value_o !== e_value) begin errors++; $display("FAIL play_value cyc %0d got %h exp %h", i, value_o, e_value); end
      checks++; if (mem_req_o !== m_out) begin errors++; $display("FAIL play_req cyc %0d got %b exp %b", i, mem_req_o, m_out); end
      if (m_out) begin
        checks++; if (mem_addr_o !== e_addr) begin errors++; $display("FAIL play_addr cyc %0d got %h exp %h", i, mem_addr_o, e_addr); end
      end
      checks++; if (restart_o !== e_restart) begin errors++; $display("FAIL play_restart cyc %0d got %b exp %b", i, restart_o, e_restart); end
    end
    enable_i = 1'b0;
    cycle();
  endtask

  task automatic test_underrun();
    do_reset();
    start_addr_i = 16'($urandom); length_i = 15'd3; period_i = 15'd0; volume_i = 7'd64;
    ack_delay = 20;
    enable_i = 1'b1;
    for (int i = 0; i < 90; i++) begin
      cycle();
      checks++; if (underrun_o !== e_underrun) begin errors++; $display("FAIL underrun cyc %0d got %b exp %b", i, underrun_o, e_underrun); end
      checks++; if (value_o !== e_value) begin errors++; $display("FAIL starve_value cyc %0d got %h exp %h", i, value_o, e_value); end
      checks++; if (mem_req_o !== m_out) begin errors++; $display("FAIL starve_req cyc %0d got %b exp %b", i, mem_req_o, m_out); end
    end
    enable_i = 1'b0;
    cycle();
  endtask

  task automatic test_volume();
    logic [6:0] vols[4];
    vols = '{7'd127, 7'd32, 7'd0, 7'd64};
    do_reset();
    start_addr_i = 16'h2000; length_i = 15'd0; period_i = 15'd1; ack_delay = 0;
    for (int i = 0; i < 32; i++) data_q.push_back(16'h7F80);
    volume_i = vols[0];
    enable_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      volume_i = vols[j];
      for (int i = 0; i < 12; i++) begin
        cycle();
        checks++; if (value_o !== e_value) begin errors++; $display("FAIL vol%0d_value cyc %0d got %h exp %h", vols[j], i, value_o, e_value); end
      end
    end
    enable_i = 1'b0;
    cycle();
  endtask

  task automatic test_stop();
    do_reset();
    start_addr_i = 16'($urandom); length_i = 15'd2; period_i = 15'd2; volume_i = 7'd64;
    ack_delay = 5;
    enable_i = 1'b1;
    cycle(); cycle();
    enable_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++; if (mem_req_o !== m_out) begin errors++; $display("FAIL stop_req cyc %0d got %b exp %b", i, mem_req_o, m_out); end
      checks++; if (value_o !== 8'h80) begin errors++; $display("FAIL stop_value cyc %0d got %h exp 80", i, value_o); end
    end
    start_addr_i = 16'($urandom);
    enable_i = 1'b1;
    cycle();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL reenable_req got %b exp 1", mem_req_o); end
    checks++; if (mem_addr_o !== start_addr_i) begin errors++; $display("FAIL reenable_addr got %h exp %h", mem_addr_o, start_addr_i); end
    enable_i = 1'b0;
    cycle();
  endtask

  task automatic test_collision();
    for (int d = 0; d < 6; d++) begin
      do_reset();
      start_addr_i = 16'hFFFE; length_i = 15'd0; period_i = 15'd2; volume_i = 7'd64;
      ack_delay = d;
      enable_i = 1'b1;
      for (int i = 0; i < 30; i++) begin
        cycle();
        checks++; if (underrun_o !== e_underrun) begin errors++; $display("FAIL coll_underrun d%0d cyc %0d got %b exp %b", d, i, underrun_o, e_underrun); end
        checks++; if (value_o !== e_value) begin errors++; $display("FAIL coll_value d%0d cyc %0d got %h exp %h", d, i, value_o, e_value); end
        checks++; if (mem_req_o !== m_out) begin errors++; $display("FAIL coll_req d%0d cyc %0d got %b exp %b", d, i, mem_req_o, m_out); end
      end
      enable_i = 1'b0;
      cycle();
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start_addr_i = 16'h4000; length_i = 15'd5; period_i = 15'd1; ack_delay = 10;
    enable_i = 1'b1;
    cycle(); cycle(); cycle();
    reset_ni = 1'b0;
    cycle();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL midrst_req got %b exp 0", mem_req_o); end
    checks++; if (value_o !== 8'h80) begin errors++; $display("FAIL midrst_value got %h exp 80", value_o); end
    checks++; if (restart_o !== 1'b0) begin errors++; $display("FAIL midrst_restart got %b exp 0", restart_o); end
    reset_ni = 1'b1; enable_i = 1'b0; force_ack = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL stray_ack_req cyc %0d got %b exp 0", i, mem_req_o); end
      checks++; if (restart_o !== 1'b0) begin errors++; $display("FAIL stray_ack_restart cyc %0d got %b exp 0", i, restart_o); end
    end
    force_ack = 0;
  endtask

  task automatic test_random();
    do_reset();
    spurious = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) enable_i = ~enable_i;
      if ($urandom_range(0, 15) == 0) volume_i = 7'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        start_addr_i = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
        length_i = 15'($urandom_range(0, 3));
      end
      if (m_mode == 0) period_i = 15'($urandom_range(0, 4));
      if (!m_out) ack_delay = $urandom_range(0, 6);
      reset_ni = ($urandom_range(0, 1499) != 0);
      cycle();
      checks++; if (value_o !== e_value) begin errors++; $display("FAIL rnd_value cyc %0d got %h exp %h", i, value_o, e_value); end
      checks++; if (mem_req_o !== m_out) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", i, mem_req_o, m_out); end
      if (m_out) begin
        checks++; if (mem_addr_o !== e_addr) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, mem_addr_o, e_addr); end
      end
      checks++; if (restart_o !== e_restart) begin errors++; $display("FAIL rnd_restart cyc %0d got %b exp %b", i, restart_o, e_restart); end
      checks++; if (underrun_o !== e_underrun) begin errors++; $display("FAIL rnd_underrun cyc %0d got %b exp %b", i, underrun_o, e_underrun); end
    end
    spurious = 0;
  endtask

  initial begin
    reset_ni = 1'b0; enable_i = 1'b0;
    start_addr_i = 16'h0; length_i = 15'd0; period_i = 15'd0; volume_i = 7'd64;
    mem_ack_i = 1'b0; mem_data_i = 16'h0;
    m_mode = 0; m_out = 0; m_cur = 8'h00; m_start = 16'h0; m_idx = 0; m_len = 15'd0;
    m_k = 0; m_p = 0;
    #1;
    test_reset();
    test_playback();
    test_underrun();
    test_volume();
    test_stop();
    test_collision();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
